// File: rtl/video_pattern_pkg.sv
// Shared colour-band pattern definitions: colour constants, 2-bit colour-state
// encoding and default geometry, common to the pattern source and checker.
package video_pattern_pkg;

  typedef enum logic [1:0] {C0 = 2'd0, C1 = 2'd1, C2 = 2'd2, C3 = 2'd3} color_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} chk_state_e;

  localparam logic [23:0] TURQUOISE = 24'h1ABC9C;  // 26,188,156
  localparam logic [23:0] CARROT    = 24'hE67E22;  // 230,126,34
  localparam logic [23:0] SUNFLOWER = 24'hF1C40F;  // 241,196,15
  localparam logic [23:0] EMERALD   = 24'h2ECC71;  // 46,204,113

  localparam int SEG_LEN_DEF       = 80;
  localparam int SEGS_PER_BAND_DEF = 200;

  function automatic logic [23:0] color_rgb(color_e c);
    case (c)
      C0:      return TURQUOISE;
      C1:      return CARROT;
      C2:      return SUNFLOWER;
      default: return EMERALD;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_checker_pattern_model.sv
// Expected-pattern generator: position counters plus colour state, advanced
// only on accepted beats, with segment and period wrap strobes.
module pattern_model
  import video_pattern_pkg::*;
#(
  parameter int SEG_LEN       = SEG_LEN_DEF,
  parameter int SEGS_PER_BAND = SEGS_PER_BAND_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        accept,
  output logic [23:0] exp_rgb,
  output logic        seg_end,
  output logic        period_end
);

  localparam int PW = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int SW = (SEGS_PER_BAND > 1) ? $clog2(SEGS_PER_BAND) : 1;

  logic [PW-1:0] pix_cnt;
  logic [SW-1:0] seg_cnt;
  logic          band;  // 0 = band A (C0/C1), 1 = band B (C2/C3)
  color_e        color;
  logic          band_end;

  assign exp_rgb    = color_rgb(color);
  assign seg_end    = accept && (pix_cnt == PW'(SEG_LEN - 1));
  assign band_end   = seg_end && (seg_cnt == SW'(SEGS_PER_BAND - 1));
  assign period_end = band_end && band;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pix_cnt <= '0;
      seg_cnt <= '0;
      band    <= 1'b0;
      color   <= C0;
    end else if (accept) begin
      pix_cnt <= seg_end ? '0 : pix_cnt + 1'b1;
      if (seg_end) begin
        seg_cnt <= band_end ? '0 : seg_cnt + 1'b1;
        if (band_end) begin
          band  <= ~band;
          color <= band ? C0 : C2;
        end else begin
          // pair members differ only in the LSB of the encoding
          color <= color_e'({color[1], ~color[0]});
        end
      end
    end
  end

endmodule

// File: rtl/video_pattern_checker.sv
// Colour-band test-pattern sink: accepts pixels, compares against the model,
// counts mismatches per run. Optional LFSR throttle: CHECKER_BACKPRESSURE_EN.
module video_pattern_checker
  import video_pattern_pkg::*;
#(
  parameter int SEG_LEN       = SEG_LEN_DEF,
  parameter int SEGS_PER_BAND = SEGS_PER_BAND_DEF,
  parameter int NUM_PERIODS   = 4,
  parameter int ERR_W         = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [23:0]      Video,
  output logic             VideoReady,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrorCount,
  output logic [15:0]      FirstErrSeg
);

  localparam int PCW = $clog2(NUM_PERIODS + 1);

  chk_state_e     state_q, state_d;
  logic           throttle;
  logic           accept;
  logic [23:0]    exp_rgb;
  logic           seg_end, period_end;
  logic           mismatch, last_beat, have_err;
  logic [PCW-1:0] period_cnt;
  logic [15:0]    gseg;
  logic [ERR_W-1:0] err_next;

`ifdef CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign throttle = lfsr[0];
`else
  assign throttle = 1'b1;
`endif

  assign VideoReady = (state_q == RUN) && throttle;
  assign accept     = VideoReady;

  pattern_model #(.SEG_LEN(SEG_LEN), .SEGS_PER_BAND(SEGS_PER_BAND)) u_model (
    .Clock      (Clock),
    .Reset      (Reset),
    .accept     (accept),
    .exp_rgb    (exp_rgb),
    .seg_end    (seg_end),
    .period_end (period_end)
  );

  assign mismatch  = accept && (Video != exp_rgb);
  assign last_beat = period_end && (period_cnt == PCW'(NUM_PERIODS - 1));
  assign err_next  = (mismatch && !(&ErrorCount)) ? ErrorCount + 1'b1 : ErrorCount;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      ErrorCount  <= '0;
      FirstErrSeg <= 16'hFFFF;
      have_err    <= 1'b0;
      period_cnt  <= '0;
      gseg        <= '0;
    end else begin
      state_q <= state_d;
      Busy    <= (state_d == RUN);
      Done    <= last_beat;
      if (state_q == IDLE && Start) begin
        Pass        <= 1'b0;
        ErrorCount  <= '0;
        FirstErrSeg <= 16'hFFFF;
        have_err    <= 1'b0;
        period_cnt  <= '0;
        gseg        <= '0;
      end else begin
        ErrorCount <= err_next;
        // gseg still names the segment of the current pixel on its last beat
        if (mismatch && !have_err) begin
          FirstErrSeg <= gseg;
          have_err    <= 1'b1;
        end
        if (seg_end)    gseg       <= gseg + 16'd1;
        if (period_end) period_cnt <= period_cnt + 1'b1;
        if (last_beat)  Pass       <= (err_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_checker.sv
// Directed bench: golden colour-band source with corruption modes driving the checker.
module tb_video_pattern_checker;

  localparam int SL  = 4;
  localparam int SB  = 3;
  localparam int NP  = 2;
  localparam int EW  = 4;
  localparam int PER = 2 * SB * SL;

  logic          Clock = 1'b0;
  logic          Reset, Start;
  logic [23:0]   Video;
  logic          VideoReady, Busy, Done, Pass;
  logic [EW-1:0] ErrorCount;
  logic [15:0]   FirstErrSeg;

  int vectors = 0, miscompares = 0;
  int beat = 0, run_base = 0, mode = 0;
  logic rdy_s = 1'b0;

  video_pattern_checker #(.SEG_LEN(SL), .SEGS_PER_BAND(SB), .NUM_PERIODS(NP), .ERR_W(EW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Video(Video), .VideoReady(VideoReady),
    .Busy(Busy), .Done(Done), .Pass(Pass), .ErrorCount(ErrorCount), .FirstErrSeg(FirstErrSeg)
  );

  always #5 Clock = ~Clock;

  function automatic logic [23:0] golden(int k);
    int p, band, seg;
    p    = k % PER;
    band = p / (SB * SL);
    seg  = (p % (SB * SL)) / SL;
    case (band * 2 + seg % 2)
      0:       return 24'h1ABC9C;
      1:       return 24'hE67E22;
      2:       return 24'hF1C40F;
      default: return 24'h2ECC71;
    endcase
  endfunction

  always @(negedge Clock) rdy_s = VideoReady;

  always @(posedge Clock) begin
    if (Reset) beat = 0;
    else if (rdy_s) beat = beat + 1;
    #1;
    if (mode == 2) Video = 24'h000000;
    else if (mode == 1 && beat - run_base == 21) Video = golden(beat) ^ 24'h000001;
    else Video = golden(beat);
  end

  task automatic pulse_start();
    @(negedge Clock);
    Start    = 1'b1;
    run_base = beat;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 1000; n++) begin
      if (Done === 1'b1) begin cyc = n; ok = 1'b1; break; end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    repeat (3) @(negedge Clock);
    vectors += 6;
    if (VideoReady !== 1'b0) begin miscompares++; $display("FAIL rst_vr got %b want 0", VideoReady); end
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", Busy); end
    if (Done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", Done); end
    if (Pass !== 1'b0) begin miscompares++; $display("FAIL rst_pass got %b want 0", Pass); end
    if (ErrorCount !== 4'd0) begin miscompares++; $display("FAIL rst_err got %0d want 0", ErrorCount); end
    if (FirstErrSeg !== 16'hFFFF) begin miscompares++; $display("FAIL rst_fes got %h want ffff", FirstErrSeg); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_golden();
    int cyc; bit ok;
    mode = 0;
    pulse_start();
    vectors++;
    if (Busy !== 1'b1) begin miscompares++; $display("FAIL gold_busy got %b want 1", Busy); end
    wait_done(cyc, ok);
    vectors += 5;
    if (!ok) begin miscompares++; $display("FAIL gold_done_timeout got none want Done"); end
    if (beat - run_base !== 48) begin miscompares++; $display("FAIL gold_beats got %0d want 48", beat - run_base); end
    if (Pass !== 1'b1) begin miscompares++; $display("FAIL gold_pass got %b want 1", Pass); end
    if (ErrorCount !== 4'd0) begin miscompares++; $display("FAIL gold_err got %0d want 0", ErrorCount); end
    if (FirstErrSeg !== 16'hFFFF) begin miscompares++; $display("FAIL gold_fes got %h want ffff", FirstErrSeg); end
`ifdef CHECKER_BACKPRESSURE_EN
    vectors++;
    if (cyc <= 49) begin miscompares++; $display("FAIL gold_bp_latency got %0d want >49", cyc); end
`else
    vectors++;
    if (cyc !== 49) begin miscompares++; $display("FAIL gold_latency got %0d want 49", cyc); end
`endif
    @(negedge Clock);
    vectors += 4;
    if (Done !== 1'b0) begin miscompares++; $display("FAIL gold_done_width got %b want 0", Done); end
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL gold_busy_after got %b want 0", Busy); end
    if (VideoReady !== 1'b0) begin miscompares++; $display("FAIL gold_vr_after got %b want 0", VideoReady); end
    if (Pass !== 1'b1) begin miscompares++; $display("FAIL gold_pass_hold got %b want 1", Pass); end
  endtask

  task automatic test_corrupt();
    int cyc; bit ok;
    mode = 1;
    pulse_start();
    wait_done(cyc, ok);
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL corr_done_timeout got none want Done"); end
    if (ErrorCount !== 4'd1) begin miscompares++; $display("FAIL corr_err got %0d want 1", ErrorCount); end
    if (FirstErrSeg !== 16'd5) begin miscompares++; $display("FAIL corr_fes got %0d want 5", FirstErrSeg); end
    if (Pass !== 1'b0) begin miscompares++; $display("FAIL corr_pass got %b want 0", Pass); end
    mode = 0;
  endtask

  task automatic test_saturate();
    int cyc; bit ok;
    mode = 2;
    pulse_start();
    wait_done(cyc, ok);
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL sat_done_timeout got none want Done"); end
    if (ErrorCount !== 4'd15) begin miscompares++; $display("FAIL sat_err got %0d want 15", ErrorCount); end
    if (FirstErrSeg !== 16'd0) begin miscompares++; $display("FAIL sat_fes got %0d want 0", FirstErrSeg); end
    if (Pass !== 1'b0) begin miscompares++; $display("FAIL sat_pass got %b want 0", Pass); end
    mode = 0;
  endtask

  task automatic test_start_in_run();
    int cyc; bit ok;
    pulse_start();
    repeat (5) @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(cyc, ok);
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL sir_done_timeout got none want Done"); end
    if (beat - run_base !== 48) begin miscompares++; $display("FAIL sir_beats got %0d want 48", beat - run_base); end
    if (ErrorCount !== 4'd0) begin miscompares++; $display("FAIL sir_err_cleared got %0d want 0", ErrorCount); end
    if (Pass !== 1'b1) begin miscompares++; $display("FAIL sir_pass got %b want 1", Pass); end
`ifndef CHECKER_BACKPRESSURE_EN
    vectors++;
    if (cyc !== 43) begin miscompares++; $display("FAIL sir_latency got %0d want 43", cyc); end
`endif
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok;
    mode = 2;
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (beat - run_base >= 10) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL mid_beats_timeout got %0d want 10", beat - run_base); end
    if (ErrorCount === 4'd0) begin miscompares++; $display("FAIL mid_err_pre got 0 want nonzero"); end
    Reset = 1'b1;
    @(negedge Clock);
    vectors += 4;
    if (VideoReady !== 1'b0) begin miscompares++; $display("FAIL mid_vr got %b want 0", VideoReady); end
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", Busy); end
    if (ErrorCount !== 4'd0) begin miscompares++; $display("FAIL mid_err got %0d want 0", ErrorCount); end
    if (FirstErrSeg !== 16'hFFFF) begin miscompares++; $display("FAIL mid_fes got %h want ffff", FirstErrSeg); end
    Reset = 1'b0;
    mode  = 0;
    pulse_start();
    wait_done(cyc, ok);
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL mid_rerun_timeout got none want Done"); end
    if (beat - run_base !== 48) begin miscompares++; $display("FAIL mid_rerun_beats got %0d want 48", beat - run_base); end
    if (ErrorCount !== 4'd0) begin miscompares++; $display("FAIL mid_rerun_err got %0d want 0", ErrorCount); end
    if (Pass !== 1'b1) begin miscompares++; $display("FAIL mid_rerun_pass got %b want 1", Pass); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Video = 24'h0;
    test_reset();
    test_golden();
    test_corrupt();
    test_saturate();
    test_start_in_run();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
